pulse_widen: RTL and testbench
==============================

Name: pulse_widen

Overview:
- Pulse stretcher. Any input pulse, including a single-cycle one, becomes an output pulse at least N clock cycles wide.
- Sits between a fast event source (strobes, error flags, handshake blips) and a consumer that needs a minimum pulse width, e.g. slower sampling logic, LEDs or debug taps.
- Synchronous to one clock. Input is assumed already synchronous to clk.

Parameters:
- N, default 4: minimum output pulse width in clk cycles. Legal range >= 1. N = 1 makes the block a registered pass-through (level mode).
- EDGE_TRIG, default 0: 0 = level mode, where every cycle `in` is sampled high (re)starts the window. 1 = edge mode, where only a 0->1 transition of the sampled `in` triggers.
- RETRIG, default 1: edge mode only. 1 = a trigger while `out` is high restarts the N-cycle window. 0 = triggers while `out` is high are ignored. No effect in level mode.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in, input, 1: pulse/level to widen, sampled on rising clk.
- out, input/output: output, 1: widened pulse, registered.

Behaviour:
- State: down-counter `cnt` of width $clog2(N+1) (minimum 1 bit); registered `out`; registered `in_d` (previous sample, edge mode).
- Reset (asynchronous, rst=1): out=0, cnt=0, in_d=0 immediately. Held while rst is high.
- After reset is released, the first rising edge evaluates normally. A high `in` at that edge triggers in level mode. In edge mode it also triggers, since in_d=0.
- trig definition:
  - Level mode: trig = in.
  - Edge mode: trig = in & ~in_d.
  - in_d <= in every edge.
- Per rising edge, in priority order:
  - trig and (out==0 or RETRIG==1 or EDGE_TRIG==0): out<=1, cnt<=N-1.
  - else if cnt!=0: out<=1, cnt<=cnt-1.
  - else: out<=0.
- Latency: out rises at the same clock edge that samples `in` high, i.e. a 1-cycle register delay from `in`.
- Level mode width: `in` sampled high for H consecutive edges gives out high for exactly H+N-1 cycles. Equivalently, out = OR of the last N samples of `in`.
- Edge mode width:
  - Each accepted trigger gives exactly N cycles of high output from its edge.
  - A long input level produces only N cycles.
  - With RETRIG=1, a retrigger at cycle k of a window extends the high output to k+N from the window start.
- Back-to-back pulses: separate input pulses whose stretched windows overlap or abut merge into one continuous high output. There is no forced low gap.
- Glitch behaviour: changes in `in` between clock edges are invisible. Only sampled values matter.
- No combinational path from in to out.

Test Plan:
- Level mode, clk period 10 ns (edges at 5, 15, ...), in high 44..100 ns (6 sampled edges, 45..95). N=4: out high from edge 45 until the edge at 135, i.e. 9 cycles. N=2: low at 115, 7 cycles. N=3: low at 125, 8 cycles.
- Single-cycle pulse, in high 200..210 ns (sampled only at 205). N=4: out high 205->245, exactly 4 cycles. N=2: 205->225. N=3: 205->235.
- N=1, level mode: out equals `in` delayed one cycle, for both pulses above.
- EDGE_TRIG=1, N=4, in held high for 10 cycles: out high exactly 4 cycles after the rise, then low while `in` is still high. Second rise after a low cycle: another 4 cycles.
- EDGE_TRIG=1, N=4, rising edges 2 cycles apart:
  - RETRIG=1: out high 6 cycles.
  - RETRIG=0: out high 4 cycles; the second edge is ignored.
- Assert rst mid-pulse, asynchronously between edges: out drops to 0 immediately. After release with in=0, out stays 0. An `in` pulse afterwards yields a full N-cycle window.

Source files
------------

// File: rtl/pulse_widen.sv
// pulse_widen: pulse stretcher. Any sampled-high input (or input rising edge in
// edge mode) produces a registered output pulse at least N clk cycles wide.
// Overlapping or abutting windows merge into one continuous high output.
//
// Parameters:
//   N         minimum output width in cycles (>= 1; N=1 gives a registered copy)
//   EDGE_TRIG 0: every high sample (re)starts the window; 1: only 0->1 edges
//   RETRIG    edge mode only; 1: a trigger while out is high restarts the window
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   in   pulse/level to widen, synchronous to clk
//   out  widened pulse, registered (no combinational path from in)
module pulse_widen #(
  parameter int N         = 4,
  parameter int EDGE_TRIG = 0,
  parameter int RETRIG    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic          in_d;
  logic          trig;
  logic          accept;

  always_comb begin
    trig   = (EDGE_TRIG != 0) ? (in & ~in_d) : in;
    // Non-retriggerable edge mode ignores triggers while the window is open.
    accept = trig & (~out | (RETRIG != 0) | (EDGE_TRIG == 0));
  end

  // cnt holds the number of further high cycles still owed after this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= 1'b0;
      cnt  <= '0;
      in_d <= 1'b0;
    end else begin
      in_d <= in;
      if (accept) begin
        out <= 1'b1;
        cnt <= CW'(N - 1);
      end else if (cnt != '0) begin
        out <= 1'b1;
        cnt <= cnt - 1'b1;
      end else begin
        out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_widen.sv
// tb_pulse_widen: drives one input into six pulse_widen configurations in
// parallel and scoreboards their outputs against independent models:
//   bit0 N=4 level, bit1 N=2 level, bit2 N=3 level, bit3 N=1 level,
//   bit4 N=4 edge retrig, bit5 N=4 edge non-retrig.
// Level expectation = OR of the last N samples; edge expectation = cycle index
// below the end of the last accepted window.
module tb_pulse_widen;

  logic       clk;
  logic       rst;
  logic       in;
  logic [5:0] outs;

  pulse_widen #(.N(4), .EDGE_TRIG(0), .RETRIG(1)) u_l4 (.clk(clk), .rst(rst), .in(in), .out(outs[0]));
  pulse_widen #(.N(2), .EDGE_TRIG(0), .RETRIG(1)) u_l2 (.clk(clk), .rst(rst), .in(in), .out(outs[1]));
  pulse_widen #(.N(3), .EDGE_TRIG(0), .RETRIG(1)) u_l3 (.clk(clk), .rst(rst), .in(in), .out(outs[2]));
  pulse_widen #(.N(1), .EDGE_TRIG(0), .RETRIG(1)) u_l1 (.clk(clk), .rst(rst), .in(in), .out(outs[3]));
  pulse_widen #(.N(4), .EDGE_TRIG(1), .RETRIG(1)) u_er (.clk(clk), .rst(rst), .in(in), .out(outs[4]));
  pulse_widen #(.N(4), .EDGE_TRIG(1), .RETRIG(0)) u_en (.clk(clk), .rst(rst), .in(in), .out(outs[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] exp_q[$];

  // model state
  logic [3:0] hist;
  logic       prev;
  logic       last5;
  int         cyc;
  int         end4;
  int         end5;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] exp);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s[%0d]", tag, i), outs[i], exp[i]);
  endtask

  task automatic model_reset();
    hist  = '0;
    prev  = 1'b0;
    last5 = 1'b0;
    cyc   = 0;
    end4  = 0;
    end5  = 0;
  endtask

  // At a negedge: compare the expectation for the edge just passed, then drive
  // the next input value and push its expected result for the coming edge.
  task automatic cycle(input logic v, input bit glitch = 1'b0);
    logic [5:0] e;
    logic       rise;
    @(negedge clk);
    if (exp_q.size() > 0) chk_all("out", exp_q.pop_front());
    if (glitch) begin
      in = ~v;
      #1;
      in = v;
    end else begin
      in = v;
    end
    hist = {hist[2:0], v};
    rise = v & ~prev;
    prev = v;
    if (rise) end4 = cyc + 4;
    if (rise && !last5) end5 = cyc + 4;
    e[0] = |hist[3:0];
    e[1] = |hist[1:0];
    e[2] = |hist[2:0];
    e[3] = hist[0];
    e[4] = (cyc < end4);
    e[5] = (cyc < end5);
    last5 = e[5];
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  task automatic drain();
    @(negedge clk);
    while (exp_q.size() > 0) chk_all("out", exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    model_reset();
    #2;
    chk_all("reset", 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all("reset_rel", 6'b0);

    // high on the first edge after reset triggers in both modes
    run(1'b1, 1);  run(1'b0, 6);
    // six-sample level
    run(1'b1, 6);  run(1'b0, 10);
    // single-cycle pulse
    run(1'b1, 1);  run(1'b0, 8);
    // long level, then a second rise after one low cycle
    run(1'b1, 10); run(1'b0, 1); run(1'b1, 3); run(1'b0, 8);
    // rises two cycles apart: retrig extends, non-retrig ignores
    run(1'b1, 1);  run(1'b0, 1); run(1'b1, 1); run(1'b0, 8);
    // rise exactly at the window end of the non-retrig instance
    run(1'b1, 1);  run(1'b0, 3); run(1'b1, 1); run(1'b0, 8);
    // glitches between edges are invisible
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); run(1'b0, 6);

    // async reset mid-pulse
    run(1'b1, 2);
    drain();
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 6'b0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 6'b0);
    @(negedge clk);
    rst = 1'b0;
    in  = 1'b0;
    model_reset();
    run(1'b0, 5);
    run(1'b1, 1);  run(1'b0, 8);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
